// File: rtl/dig_pot_pkg.sv
// Shared constants, FSM state type and command-word builder for the digital pot SPI master.
package dig_pot_pkg;

    localparam logic [1:0]  POT_CMD_WRITE = 2'b01;
    localparam int unsigned POT_WIPE0_BIT = 8;
    localparam int unsigned POT_WIPE1_BIT = 9;
    localparam logic [7:0]  POT_MID_RAIL  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRONT,
        ST_SHIFT,
        ST_BACK,
        ST_DONE
    } pot_state_t;

    function automatic logic [15:0] pot_build_cmd(input logic [1:0] sel, input logic [7:0] val);
        logic [15:0] cmd;
        cmd                = '0;
        cmd[13:12]         = POT_CMD_WRITE;
        cmd[POT_WIPE1_BIT] = sel[1];
        cmd[POT_WIPE0_BIT] = sel[0];
        cmd[7:0]           = val;
        return cmd;
    endfunction

endpackage

// File: rtl/dig_pot_sclk_div.sv
// Half-period counter producing the registered SCLK level and fall/rise strobes.
// Held in reset (SCLK high, counter cleared) whenever en is low.
module dig_pot_sclk_div #(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic toggle_en,
    output logic sclk,
    output logic half_end,
    output logic fall,
    output logic rise
);

    localparam int unsigned H  = SCLK_DIV / 2;
    localparam int unsigned CW = $clog2(H);

    logic [CW-1:0] cnt;

    assign half_end = en && (cnt == CW'(H - 1));
    assign fall     = half_end && toggle_en && sclk;
    assign rise     = half_end && toggle_en && !sclk;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else begin
            if (half_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (half_end && toggle_en) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/dig_pot_mstr.sv
// SPI master serialising one 16-bit pot write per request (SS_n/SCLK/MOSI, MSB first).
// Optional wiper shadow registers and redundant-write elision: define DIG_POT_SHADOW_EN.
module dig_pot_mstr
    import dig_pot_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wrt,
    input  logic [1:0] wiper_sel,
    input  logic [7:0] wiper_val,
    output logic       SS_n,
    output logic       SCLK,
    output logic       MOSI,
    output logic       busy,
    output logic       done
`ifdef DIG_POT_SHADOW_EN
    ,
    output logic [7:0] shadow_0,
    output logic [7:0] shadow_1
`endif
);

    pot_state_t  state, state_nxt;
    logic [15:0] sreg, sreg_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic        ss_n_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic        div_en, toggle_en, half_end, sclk_fall, sclk_rise;
    logic        accept, elide, last_high;

    assign accept = (state == ST_IDLE) && wrt;

    // bit_cnt wraps to 0 on the 16th rise, so SCLK high with bit_cnt==0 marks the final high half
    assign last_high = SCLK && (bit_cnt == 4'd0);

`ifdef DIG_POT_SHADOW_EN
    logic [1:0] sel_q;
    logic [7:0] val_q;

    assign elide = (!wiper_sel[0] || (shadow_0 == wiper_val)) &&
                   (!wiper_sel[1] || (shadow_1 == wiper_val));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q    <= '0;
            val_q    <= '0;
            shadow_0 <= POT_MID_RAIL;
            shadow_1 <= POT_MID_RAIL;
        end else begin
            if (accept && !elide) begin
                sel_q <= wiper_sel;
                val_q <= wiper_val;
            end
            if (state == ST_DONE) begin
                if (sel_q[0]) shadow_0 <= val_q;
                if (sel_q[1]) shadow_1 <= val_q;
            end
        end
    end
`else
    assign elide = 1'b0;
`endif

    dig_pot_sclk_div #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (div_en),
        .toggle_en(toggle_en),
        .sclk     (SCLK),
        .half_end (half_end),
        .fall     (sclk_fall),
        .rise     (sclk_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            SS_n    <= 1'b1;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            SS_n    <= ss_n_nxt;
            MOSI    <= mosi_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept && !elide)      state_nxt = ST_FRONT;
            ST_FRONT: if (half_end)              state_nxt = ST_SHIFT;
            ST_SHIFT: if (half_end && last_high) state_nxt = ST_BACK;
            ST_BACK:  if (half_end)              state_nxt = ST_DONE;
            ST_DONE:                             state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        div_en      = state inside {ST_FRONT, ST_SHIFT, ST_BACK};
        toggle_en   = (state == ST_FRONT) || ((state == ST_SHIFT) && !last_high);
        sreg_nxt    = sreg;
        bit_cnt_nxt = bit_cnt;

        if (accept && !elide) begin
            sreg_nxt = pot_build_cmd(wiper_sel, wiper_val);
        end
        // The fall that ends FRONT leaves bit 15 in place; later falls advance the word
        if ((state == ST_SHIFT) && sclk_fall) begin
            sreg_nxt = {sreg[14:0], 1'b0};
        end
        if (state == ST_IDLE) begin
            bit_cnt_nxt = '0;
        end else if ((state == ST_SHIFT) && sclk_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
        end

        ss_n_nxt = !(state_nxt inside {ST_FRONT, ST_SHIFT, ST_BACK});
        mosi_nxt = ss_n_nxt ? 1'b0 : sreg_nxt[15];
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE) || (accept && elide);
    end

endmodule

// File: tb/tb_dig_pot_mstr.sv
// Randomised bench for dig_pot_mstr: a behavioural pot slave decodes the SPI pins and is
// compared against wiper values predicted from the requests. Honours DIG_POT_SHADOW_EN.
module tb_dig_pot_mstr;

    localparam int unsigned DIV       = 8;
    localparam int unsigned FRAME_LOW = 17 * DIV;
    localparam int unsigned BOUND     = 40 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wrt = 1'b0;
    logic [1:0] wiper_sel = '0;
    logic [7:0] wiper_val = '0;
    logic       SS_n, SCLK, MOSI, busy, done;
`ifdef DIG_POT_SHADOW_EN
    logic [7:0] shadow_0, shadow_1;
`endif

    always #5 clk = ~clk;

    dig_pot_mstr #(
        .SCLK_DIV(DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrt      (wrt),
        .wiper_sel(wiper_sel),
        .wiper_val(wiper_val),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .busy     (busy),
        .done     (done)
`ifdef DIG_POT_SHADOW_EN
        ,
        .shadow_0 (shadow_0),
        .shadow_1 (shadow_1)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- pin monitor and behavioural pot slave ----
    logic        prev_sclk = 1'b1, prev_ssn = 1'b1, prev_done = 1'b0;
    logic [15:0] rx = '0;
    int          rx_bits = 0, low_cnt = 0, rises = 0, falls = 0;
    int          high_run = 0, last_gap = 0, busy_run = 0;
    int          done_cnt = 0, done_wide = 0, sclk_idle_bad = 0;
    logic [15:0] fr_rx_q[$];
    int          fr_bits_q[$], fr_low_q[$], fr_rise_q[$], fr_fall_q[$], busy_len_q[$];
    logic [7:0]  pot_w0 = 8'h80, pot_w1 = 8'h80;

    always @(negedge clk) begin
        if (!SS_n && prev_ssn) begin
            last_gap = high_run;
            high_run = 0;
        end
        if (!SS_n) begin
            low_cnt++;
            if (SCLK && !prev_sclk) begin
                rx = {rx[14:0], MOSI};
                rx_bits++;
                rises++;
            end
            if (!SCLK && prev_sclk) falls++;
        end else begin
            high_run++;
            if (!SCLK) sclk_idle_bad++;
        end
        if (SS_n && !prev_ssn) begin
            fr_rx_q.push_back(rx);
            fr_bits_q.push_back(rx_bits);
            fr_low_q.push_back(low_cnt);
            fr_rise_q.push_back(rises);
            fr_fall_q.push_back(falls);
            if (rx_bits == 16 && rx[15:12] == 4'b0001) begin
                if (rx[8]) pot_w0 = rx[7:0];
                if (rx[9]) pot_w1 = rx[7:0];
            end
            rx = '0; rx_bits = 0; low_cnt = 0; rises = 0; falls = 0;
        end
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_len_q.push_back(busy_run);
            busy_run = 0;
        end
        if (done) done_cnt++;
        if (done && prev_done) done_wide++;
        prev_sclk = SCLK;
        prev_ssn  = SS_n;
        prev_done = done;
    end

    // ---- reference model state ----
    logic [7:0] ref_w0 = 8'h80, ref_w1 = 8'h80;
    logic [7:0] ref_sh0 = 8'h80, ref_sh1 = 8'h80;
    int         n_writes = 0;

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [7:0] val, input bit mid,
                         input bit el, output int lat);
        int cyc;
        @(posedge clk); #1;
        wrt = 1'b1; wiper_sel = sel; wiper_val = val;
        @(posedge clk); #1;
        wrt = 1'b0; wiper_sel = 2'($urandom); wiper_val = 8'($urandom);
        check("busy_after_wrt", busy, !el);
        if (mid && !el) begin
            repeat (5 * DIV) @(posedge clk);
            #1;
            wrt = 1'b1; wiper_sel = 2'b11; wiper_val = ~val;
            @(posedge clk); #1;
            wrt = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < BOUND) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("done_within_bound", cyc < BOUND, 1);
        lat = cyc;
        n_writes++;
    endtask

    task automatic verify(input logic [1:0] sel, input logic [7:0] val, input bit el);
        logic [15:0] exp_cmd;
        exp_cmd = {4'b0001, 2'b00, sel, val};
        if (el) begin
            check("elide_no_frame", fr_rx_q.size(), 0);
        end else begin
            check("frame_present", fr_rx_q.size() > 0, 1);
            if (fr_rx_q.size() > 0) begin
                check("rx_cmd", fr_rx_q.pop_front(), exp_cmd);
                check("rx_bits", fr_bits_q.pop_front(), 16);
                check("ss_n_low_cycles", fr_low_q.pop_front(), FRAME_LOW);
                check("sclk_rises", fr_rise_q.pop_front(), 16);
                check("sclk_falls", fr_fall_q.pop_front(), 16);
            end
            check("busy_len_present", busy_len_q.size() > 0, 1);
            if (busy_len_q.size() > 0) check("busy_cycles", busy_len_q.pop_front(), FRAME_LOW + 1);
        end
    endtask

    task automatic apply_ref(input logic [1:0] sel, input logic [7:0] val, input bit el);
        if (!el) begin
            if (sel[0]) begin ref_w0 = val; ref_sh0 = val; end
            if (sel[1]) begin ref_w1 = val; ref_sh1 = val; end
        end
    endtask

    task automatic check_wipers();
        check("pot_wipe_0", pot_w0, ref_w0);
        check("pot_wipe_1", pot_w1, ref_w1);
`ifdef DIG_POT_SHADOW_EN
        check("shadow_0", shadow_0, ref_sh0);
        check("shadow_1", shadow_1, ref_sh1);
`endif
    endtask

    function automatic bit predict_elide(input logic [1:0] sel, input logic [7:0] val);
        bit el;
        el = 1'b0;
`ifdef DIG_POT_SHADOW_EN
        el = (!sel[0] || ref_sh0 == val) && (!sel[1] || ref_sh1 == val);
`endif
        return el;
    endfunction

    task automatic write_and_check(input logic [1:0] sel, input logic [7:0] val, input bit mid);
        bit el;
        int lat;
        el = predict_elide(sel, val);
        issue(sel, val, mid, el, lat);
        settle();
        if (el) check("elide_done_latency", lat, 0);
        if (mid && !el) check("mid_wrt_single_frame", fr_rx_q.size(), 1);
        verify(sel, val, el);
        apply_ref(sel, val, el);
        check_wipers();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_sh0 = 8'h80;
        ref_sh1 = 8'h80;
        fr_rx_q.delete(); fr_bits_q.delete(); fr_low_q.delete();
        fr_rise_q.delete(); fr_fall_q.delete(); busy_len_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   cyc, d0, lat;
        logic [1:0] s;
        logic [7:0] v;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", SS_n, 1);
        check("rst_sclk", SCLK, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        write_and_check(2'b01, 8'hA5, 1'b0);
        write_and_check(2'b11, 8'h3C, 1'b0);
        write_and_check(2'b10, 8'h9E, 1'b1);

        // back-to-back: second wrt lands in the cycle after done
        issue(2'b01, 8'h5A, 1'b0, 1'b0, lat);
        issue(2'b10, 8'hC3, 1'b0, 1'b0, lat);
        settle();
        check("b2b_frames", fr_rx_q.size(), 2);
        check("b2b_gap_ok", last_gap >= 1, 1);
        verify(2'b01, 8'h5A, 1'b0);
        verify(2'b10, 8'hC3, 1'b0);
        apply_ref(2'b01, 8'h5A, 1'b0);
        apply_ref(2'b10, 8'hC3, 1'b0);
        check_wipers();

        // reset during SHIFT aborts the frame without done or a wiper change
        @(posedge clk); #1;
        wrt = 1'b1; wiper_sel = 2'b11; wiper_val = 8'hE7;
        @(posedge clk); #1;
        wrt = 1'b0;
        cyc = 0;
        while (rises < 8 && cyc < BOUND) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("reach_bit7", cyc < BOUND, 1);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ss_n", SS_n, 1);
        check("abort_sclk", SCLK, 1);
        check("abort_busy", busy, 0);
        check("abort_mosi", MOSI, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, d0);
        check("abort_bits", fr_bits_q.size() > 0 ? fr_bits_q[fr_bits_q.size()-1] : -1, 8);
        ref_sh0 = 8'h80; ref_sh1 = 8'h80;
        fr_rx_q.delete(); fr_bits_q.delete(); fr_low_q.delete();
        fr_rise_q.delete(); fr_fall_q.delete(); busy_len_q.delete();
        check_wipers();

        for (int i = 0; i < 8; i++) begin
            s = 2'($urandom_range(0, 3));
            v = 8'($urandom);
`ifdef DIG_POT_SHADOW_EN
            if ($urandom_range(0, 2) == 0) begin
                s = 2'b01;
                v = ref_sh0;
            end
`endif
            write_and_check(s, v, $urandom_range(0, 3) == 0);
        end

`ifdef DIG_POT_SHADOW_EN
        do_reset();
        write_and_check(2'b01, 8'h80, 1'b0);
        write_and_check(2'b01, 8'h81, 1'b0);
        check("shadow_0_81", shadow_0, 8'h81);
`endif

        repeat (4) @(negedge clk);
        #1;
        check("done_pulse_count", done_cnt, n_writes);
        check("done_single_cycle", done_wide, 0);
        check("sclk_idles_high", sclk_idle_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
